// File: rtl/tank_pkg.sv
// Shared types and codes for the tank hit arbiter: FSM states, bullet-state
// codes, winner codes and default box sizes.
package tank_pkg;

    localparam int TANK_W_DEF   = 32;
    localparam int BULLET_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PLAY   = 2'b01,
        FREEZE = 2'b10,
        OVER   = 2'b11
    } state_t;

    localparam logic [1:0] BULLET_NONE = 2'b00;
    localparam logic [1:0] BULLET_LIVE = 2'b01;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P0   = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Winner code from the two "reached WIN_SCORE" flags; both set means draw.
    function automatic logic [1:0] winner_code(input logic win0, input logic win1);
        return {win1, win0};
    endfunction

endpackage

// File: rtl/tank_hit_arbiter_if.sv
// Bundle between the two tank/bullet controllers and the hit arbiter.
// master = controller side, slave = arbiter side.
interface tank_hit_arbiter_if;
    import tank_pkg::*;

    logic       start;
    logic [9:0] tank0_X;
    logic [9:0] tank0_Y;
    logic [9:0] tank1_X;
    logic [9:0] tank1_Y;
    logic [9:0] bullet0_X;
    logic [9:0] bullet0_Y;
    logic [9:0] bullet1_X;
    logic [9:0] bullet1_Y;
    logic [1:0] hit0;
    logic [1:0] hit1;

    logic [1:0] bull_hit0;
    logic [1:0] bull_hit1;
    logic [3:0] score0;
    logic [3:0] score1;
    state_t     state;
    logic       freeze;
    logic       round_reset;
    logic [1:0] winner;
    logic       game_over;

    modport master (
        output start, tank0_X, tank0_Y, tank1_X, tank1_Y,
               bullet0_X, bullet0_Y, bullet1_X, bullet1_Y, hit0, hit1,
        input  bull_hit0, bull_hit1, score0, score1, state, freeze,
               round_reset, winner, game_over
    );

    modport slave (
        input  start, tank0_X, tank0_Y, tank1_X, tank1_Y,
               bullet0_X, bullet0_Y, bullet1_X, bullet1_Y, hit0, hit1,
        output bull_hit0, bull_hit1, score0, score1, state, freeze,
               round_reset, winner, game_over
    );

endinterface

// File: rtl/box_overlap.sv
// Combinational inclusive overlap of box A (size A_W) and box B (size B_W).
// Coordinates are widened to 11 bits so corner + size never wraps.
module box_overlap #(
    parameter int A_W = 8,
    parameter int B_W = 32
) (
    input  logic [9:0] a_x_i,
    input  logic [9:0] a_y_i,
    input  logic [9:0] b_x_i,
    input  logic [9:0] b_y_i,
    output logic       hit_o
);
    logic [10:0] ax, ay, bx, by;
    logic        x_ov, y_ov;

    assign ax = {1'b0, a_x_i};
    assign ay = {1'b0, a_y_i};
    assign bx = {1'b0, b_x_i};
    assign by = {1'b0, b_y_i};

    assign x_ov  = (ax <= bx + 11'(B_W)) && (bx <= ax + 11'(A_W));
    assign y_ov  = (ay <= by + 11'(B_W)) && (by <= ay + 11'(A_W));
    assign hit_o = x_ov && y_ov;

endmodule

// File: rtl/tank_hit_arbiter.sv
// Per-frame bullet-vs-tank hit test, scoring and round/game FSM; outputs are
// registered one Clk after the synchronised frame edge. Optional: BULLET_CLASH_EN.
module tank_hit_arbiter
    import tank_pkg::*;
#(
    parameter int TANK_W        = TANK_W_DEF,
    parameter int BULLET_W      = BULLET_W_DEF,
    parameter int WIN_SCORE     = 5,
    parameter int FREEZE_FRAMES = 60
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_clk,
    tank_hit_arbiter_if.slave   bus
);

    logic fc_meta_q, fc_sync_q, fc_prev_q;
    logic fe;

    // frame_clk is asynchronous: two flops to synchronise, a third for the edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fc_meta_q <= 1'b0;
            fc_sync_q <= 1'b0;
            fc_prev_q <= 1'b0;
        end else begin
            fc_meta_q <= frame_clk;
            fc_sync_q <= fc_meta_q;
            fc_prev_q <= fc_sync_q;
        end
    end

    assign fe = fc_sync_q & ~fc_prev_q;

    logic ov_a, ov_b, hit_a, hit_b, clash;

    box_overlap #(.A_W(BULLET_W), .B_W(TANK_W)) u_ov_a (
        .a_x_i (bus.bullet0_X),
        .a_y_i (bus.bullet0_Y),
        .b_x_i (bus.tank1_X),
        .b_y_i (bus.tank1_Y),
        .hit_o (ov_a)
    );

    box_overlap #(.A_W(BULLET_W), .B_W(TANK_W)) u_ov_b (
        .a_x_i (bus.bullet1_X),
        .a_y_i (bus.bullet1_Y),
        .b_x_i (bus.tank0_X),
        .b_y_i (bus.tank0_Y),
        .hit_o (ov_b)
    );

    assign hit_a = (bus.hit0 == BULLET_LIVE) && ov_a;
    assign hit_b = (bus.hit1 == BULLET_LIVE) && ov_b;

`ifdef BULLET_CLASH_EN
    logic ov_c;

    box_overlap #(.A_W(BULLET_W), .B_W(BULLET_W)) u_ov_clash (
        .a_x_i (bus.bullet0_X),
        .a_y_i (bus.bullet0_Y),
        .b_x_i (bus.bullet1_X),
        .b_y_i (bus.bullet1_Y),
        .hit_o (ov_c)
    );

    assign clash = (bus.hit0 == BULLET_LIVE) && (bus.hit1 == BULLET_LIVE) && ov_c;
`else
    assign clash = 1'b0;
`endif

    state_t     state_q, state_d;
    logic [3:0] score0_q, score0_d;
    logic [3:0] score1_q, score1_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] bull_hit0_q, bull_hit0_d;
    logic [1:0] bull_hit1_q, bull_hit1_d;
    logic       freeze_q, freeze_d;
    logic       round_reset_q, round_reset_d;
    logic [1:0] winner_q, winner_d;
    logic       game_over_q, game_over_d;

    logic [3:0] score0_inc, score1_inc;
    logic       win0, win1;

    assign score0_inc = score0_q + {3'b000, hit_a};
    assign score1_inc = score1_q + {3'b000, hit_b};
    assign win0       = (score0_inc == 4'(WIN_SCORE));
    assign win1       = (score1_inc == 4'(WIN_SCORE));

    always_comb begin
        state_d       = state_q;
        score0_d      = score0_q;
        score1_d      = score1_q;
        cnt_d         = cnt_q;
        bull_hit0_d   = bull_hit0_q;
        bull_hit1_d   = bull_hit1_q;
        freeze_d      = freeze_q;
        round_reset_d = 1'b0;
        winner_d      = winner_q;
        game_over_d   = game_over_q;

        if (fe) begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d       = PLAY;
                        round_reset_d = 1'b1;
                        freeze_d      = 1'b0;
                        bull_hit0_d   = BULLET_LIVE;
                        bull_hit1_d   = BULLET_LIVE;
                    end
                end

                PLAY: begin
                    if (clash) begin
                        // Mutual kill: both bullets cleared for this frame only.
                        bull_hit0_d = BULLET_NONE;
                        bull_hit1_d = BULLET_NONE;
                    end else if (hit_a || hit_b) begin
                        score0_d    = score0_inc;
                        score1_d    = score1_inc;
                        freeze_d    = 1'b1;
                        bull_hit0_d = BULLET_NONE;
                        bull_hit1_d = BULLET_NONE;
                        if (win0 || win1) begin
                            state_d     = OVER;
                            game_over_d = 1'b1;
                            winner_d    = winner_code(win0, win1);
                        end else begin
                            state_d = FREEZE;
                            cnt_d   = 8'(FREEZE_FRAMES - 1);
                        end
                    end else begin
                        bull_hit0_d = BULLET_LIVE;
                        bull_hit1_d = BULLET_LIVE;
                    end
                end

                FREEZE: begin
                    if (cnt_q == 8'd0) begin
                        state_d       = PLAY;
                        round_reset_d = 1'b1;
                        freeze_d      = 1'b0;
                        bull_hit0_d   = BULLET_LIVE;
                        bull_hit1_d   = BULLET_LIVE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end

                OVER: begin
                    if (bus.start) begin
                        state_d       = PLAY;
                        score0_d      = 4'd0;
                        score1_d      = 4'd0;
                        winner_d      = WIN_NONE;
                        game_over_d   = 1'b0;
                        round_reset_d = 1'b1;
                        freeze_d      = 1'b0;
                        bull_hit0_d   = BULLET_LIVE;
                        bull_hit1_d   = BULLET_LIVE;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= IDLE;
            score0_q      <= 4'd0;
            score1_q      <= 4'd0;
            cnt_q         <= 8'd0;
            bull_hit0_q   <= BULLET_NONE;
            bull_hit1_q   <= BULLET_NONE;
            freeze_q      <= 1'b1;
            round_reset_q <= 1'b0;
            winner_q      <= WIN_NONE;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            score0_q      <= score0_d;
            score1_q      <= score1_d;
            cnt_q         <= cnt_d;
            bull_hit0_q   <= bull_hit0_d;
            bull_hit1_q   <= bull_hit1_d;
            freeze_q      <= freeze_d;
            round_reset_q <= round_reset_d;
            winner_q      <= winner_d;
            game_over_q   <= game_over_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.score0      = score0_q;
    assign bus.score1      = score1_q;
    assign bus.bull_hit0   = bull_hit0_q;
    assign bus.bull_hit1   = bull_hit1_q;
    assign bus.freeze      = freeze_q;
    assign bus.round_reset = round_reset_q;
    assign bus.winner      = winner_q;
    assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_tank_hit_arbiter.sv
// Directed bench for tank_hit_arbiter: reset, scoring, edge inclusivity,
// freeze timing, simultaneous win, restart and reset out of OVER.
`timescale 1ns/1ps
module tb_tank_hit_arbiter;
    import tank_pkg::*;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic frame_clk = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   rr_cnt = 0;
    int   rr0;

    tank_hit_arbiter_if bus ();

    tank_hit_arbiter dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    always #10 Clk = ~Clk;

    always @(negedge Clk) if (bus.round_reset === 1'b1) rr_cnt++;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic frame();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.tank0_X = 10'd100;   bus.tank0_Y = 10'd100;
        bus.tank1_X = 10'd540;   bus.tank1_Y = 10'd240;
        bus.bullet0_X = 10'd0;   bus.bullet0_Y = 10'd0;
        bus.bullet1_X = 10'd0;   bus.bullet1_Y = 10'd0;
        bus.hit0 = BULLET_NONE;  bus.hit1 = BULLET_NONE;
    endtask

    task automatic run_freeze();
        bus.hit0 = BULLET_NONE; bus.hit1 = BULLET_NONE;
        repeat (60) frame();
    endtask

    task automatic score_p0();
        bus.bullet0_X = 10'd540; bus.bullet0_Y = 10'd250; bus.hit0 = BULLET_LIVE;
        frame();
        run_freeze();
    endtask

    task automatic score_p1();
        bus.bullet1_X = 10'd110; bus.bullet1_Y = 10'd110; bus.hit1 = BULLET_LIVE;
        frame();
        run_freeze();
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        total++; if (bus.state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d want=%0d", bus.state, IDLE); end
        total++; if (bus.score0 !== 4'd0 || bus.score1 !== 4'd0) begin bad++; $display("FAIL rst_score got=%0d/%0d want=0/0", bus.score0, bus.score1); end
        total++; if (bus.bull_hit0 !== 2'b00 || bus.bull_hit1 !== 2'b00) begin bad++; $display("FAIL rst_bull_hit got=%b/%b want=00/00", bus.bull_hit0, bus.bull_hit1); end
        total++; if (bus.freeze !== 1'b1) begin bad++; $display("FAIL rst_freeze got=%b want=1", bus.freeze); end
        total++; if (bus.round_reset !== 1'b0 || bus.winner !== 2'b00 || bus.game_over !== 1'b0) begin bad++; $display("FAIL rst_misc got rr=%b win=%b go=%b want 0/00/0", bus.round_reset, bus.winner, bus.game_over); end
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        frame();
        total++; if (bus.state !== IDLE) begin bad++; $display("FAIL idle_no_start got=%0d want=%0d", bus.state, IDLE); end
    endtask

    task automatic test_start();
        rr0 = rr_cnt;
        bus.start = 1'b1;
        frame();
        bus.start = 1'b0;
        total++; if (bus.state !== PLAY) begin bad++; $display("FAIL start_state got=%0d want=%0d", bus.state, PLAY); end
        total++; if (rr_cnt - rr0 !== 1) begin bad++; $display("FAIL start_round_reset got=%0d pulses want=1", rr_cnt - rr0); end
        total++; if (bus.freeze !== 1'b0) begin bad++; $display("FAIL start_freeze got=%b want=0", bus.freeze); end
        total++; if (bus.bull_hit0 !== 2'b01 || bus.bull_hit1 !== 2'b01) begin bad++; $display("FAIL start_bull_hit got=%b/%b want=01/01", bus.bull_hit0, bus.bull_hit1); end
        total++; if (bus.score0 !== 4'd0 || bus.score1 !== 4'd0) begin bad++; $display("FAIL start_score got=%0d/%0d want=0/0", bus.score0, bus.score1); end
    endtask

    task automatic test_hit_freeze();
        bus.bullet0_X = 10'd540; bus.bullet0_Y = 10'd250; bus.hit0 = BULLET_LIVE;
        frame();
        total++; if (bus.score0 !== 4'd1) begin bad++; $display("FAIL hit_score0 got=%0d want=1", bus.score0); end
        total++; if (bus.bull_hit0 !== 2'b00) begin bad++; $display("FAIL hit_bull_hit0 got=%b want=00", bus.bull_hit0); end
        total++; if (bus.state !== FREEZE || bus.freeze !== 1'b1) begin bad++; $display("FAIL hit_state got=%0d frz=%b want=%0d/1", bus.state, bus.freeze, FREEZE); end
        // Enemy bullet sitting on tank0 and start held must both be ignored in FREEZE.
        bus.hit0 = BULLET_NONE;
        bus.bullet1_X = 10'd100; bus.bullet1_Y = 10'd100; bus.hit1 = BULLET_LIVE;
        bus.start = 1'b1;
        rr0 = rr_cnt;
        repeat (59) frame();
        total++; if (bus.state !== FREEZE) begin bad++; $display("FAIL freeze_59 got=%0d want=%0d", bus.state, FREEZE); end
        total++; if (bus.score1 !== 4'd0 || rr_cnt !== rr0) begin bad++; $display("FAIL freeze_ignore got score1=%0d rr=%0d want 0/0", bus.score1, rr_cnt - rr0); end
        bus.hit1 = BULLET_NONE; bus.start = 1'b0;
        frame();
        total++; if (bus.state !== PLAY) begin bad++; $display("FAIL freeze_60 got=%0d want=%0d", bus.state, PLAY); end
        total++; if (rr_cnt - rr0 !== 1) begin bad++; $display("FAIL freeze_rr got=%0d want=1", rr_cnt - rr0); end
        total++; if (bus.bull_hit0 !== 2'b01 || bus.freeze !== 1'b0) begin bad++; $display("FAIL freeze_exit got bh0=%b frz=%b want 01/0", bus.bull_hit0, bus.freeze); end
    endtask

    task automatic test_edges();
        bus.hit0 = BULLET_LIVE;
        bus.bullet0_X = 10'd573; bus.bullet0_Y = 10'd250;
        frame();
        total++; if (bus.score0 !== 4'd1 || bus.state !== PLAY) begin bad++; $display("FAIL edge_x573 got score0=%0d st=%0d want 1/PLAY", bus.score0, bus.state); end
        bus.bullet0_X = 10'd531;
        frame();
        total++; if (bus.score0 !== 4'd1 || bus.state !== PLAY) begin bad++; $display("FAIL edge_x531 got score0=%0d st=%0d want 1/PLAY", bus.score0, bus.state); end
        bus.bullet0_X = 10'd572;
        frame();
        total++; if (bus.score0 !== 4'd2 || bus.state !== FREEZE) begin bad++; $display("FAIL edge_x572 got score0=%0d st=%0d want 2/FREEZE", bus.score0, bus.state); end
        run_freeze();
        bus.hit0 = BULLET_LIVE;
        bus.bullet0_X = 10'd550; bus.bullet0_Y = 10'd273;
        frame();
        total++; if (bus.score0 !== 4'd2 || bus.state !== PLAY) begin bad++; $display("FAIL edge_y273 got score0=%0d st=%0d want 2/PLAY", bus.score0, bus.state); end
        bus.bullet0_Y = 10'd232;
        frame();
        total++; if (bus.score0 !== 4'd3 || bus.state !== FREEZE) begin bad++; $display("FAIL edge_y232 got score0=%0d st=%0d want 3/FREEZE", bus.score0, bus.state); end
        run_freeze();
    endtask

    task automatic test_own_bullet();
        rr0 = rr_cnt;
        bus.start = 1'b1;
        bus.bullet0_X = 10'd110; bus.bullet0_Y = 10'd110; bus.hit0 = BULLET_LIVE;
        frame();
        total++; if (bus.score0 !== 4'd3 || bus.score1 !== 4'd0 || bus.state !== PLAY) begin bad++; $display("FAIL own_tank got %0d/%0d st=%0d want 3/0 PLAY", bus.score0, bus.score1, bus.state); end
        bus.bullet0_X = 10'd540; bus.bullet0_Y = 10'd250; bus.hit0 = BULLET_NONE;
        frame();
        total++; if (bus.score0 !== 4'd3 || bus.state !== PLAY || bus.bull_hit0 !== 2'b01) begin bad++; $display("FAIL dead_bullet got score0=%0d st=%0d bh0=%b want 3/PLAY/01", bus.score0, bus.state, bus.bull_hit0); end
        total++; if (rr_cnt !== rr0) begin bad++; $display("FAIL play_start_ignored got rr=%0d want=0", rr_cnt - rr0); end
        bus.start = 1'b0;
    endtask

`ifdef BULLET_CLASH_EN
    task automatic test_clash();
        bus.tank1_X = 10'd290; bus.tank1_Y = 10'd190;
        bus.bullet0_X = 10'd300; bus.bullet0_Y = 10'd200; bus.hit0 = BULLET_LIVE;
        bus.bullet1_X = 10'd300; bus.bullet1_Y = 10'd200; bus.hit1 = BULLET_LIVE;
        frame();
        total++; if (bus.bull_hit0 !== 2'b00 || bus.bull_hit1 !== 2'b00) begin bad++; $display("FAIL clash_bull_hit got=%b/%b want=00/00", bus.bull_hit0, bus.bull_hit1); end
        total++; if (bus.score0 !== 4'd3 || bus.score1 !== 4'd0 || bus.state !== PLAY) begin bad++; $display("FAIL clash_state got %0d/%0d st=%0d want 3/0 PLAY", bus.score0, bus.score1, bus.state); end
        bus.tank1_X = 10'd540; bus.tank1_Y = 10'd240;
        bus.hit0 = BULLET_NONE; bus.hit1 = BULLET_NONE;
        frame();
        total++; if (bus.bull_hit0 !== 2'b01 || bus.bull_hit1 !== 2'b01) begin bad++; $display("FAIL clash_recover got=%b/%b want=01/01", bus.bull_hit0, bus.bull_hit1); end
    endtask
`endif

    task automatic test_simultaneous();
        score_p0();
        repeat (4) score_p1();
        total++; if (bus.score0 !== 4'd4 || bus.score1 !== 4'd4) begin bad++; $display("FAIL sim_setup got %0d/%0d want 4/4", bus.score0, bus.score1); end
        bus.bullet0_X = 10'd540; bus.bullet0_Y = 10'd250; bus.hit0 = BULLET_LIVE;
        bus.bullet1_X = 10'd110; bus.bullet1_Y = 10'd110; bus.hit1 = BULLET_LIVE;
        frame();
        total++; if (bus.score0 !== 4'd5 || bus.score1 !== 4'd5) begin bad++; $display("FAIL sim_score got %0d/%0d want 5/5", bus.score0, bus.score1); end
        total++; if (bus.state !== OVER || bus.game_over !== 1'b1) begin bad++; $display("FAIL sim_over got st=%0d go=%b want %0d/1", bus.state, bus.game_over, OVER); end
        total++; if (bus.winner !== 2'b11) begin bad++; $display("FAIL sim_winner got=%b want=11", bus.winner); end
        total++; if (bus.freeze !== 1'b1 || bus.bull_hit0 !== 2'b00) begin bad++; $display("FAIL sim_outputs got frz=%b bh0=%b want 1/00", bus.freeze, bus.bull_hit0); end
        bus.hit0 = BULLET_NONE; bus.hit1 = BULLET_NONE;
        frame();
        total++; if (bus.state !== OVER || bus.score0 !== 4'd5) begin bad++; $display("FAIL over_hold got st=%0d score0=%0d want OVER/5", bus.state, bus.score0); end
        rr0 = rr_cnt;
        bus.start = 1'b1;
        frame();
        bus.start = 1'b0;
        total++; if (bus.state !== PLAY || bus.score0 !== 4'd0 || bus.score1 !== 4'd0) begin bad++; $display("FAIL restart got st=%0d %0d/%0d want PLAY 0/0", bus.state, bus.score0, bus.score1); end
        total++; if (bus.winner !== 2'b00 || bus.game_over !== 1'b0 || rr_cnt - rr0 !== 1) begin bad++; $display("FAIL restart_misc got win=%b go=%b rr=%0d want 00/0/1", bus.winner, bus.game_over, rr_cnt - rr0); end
    endtask

    task automatic test_single_win_and_reset();
        repeat (4) score_p1();
        bus.bullet1_X = 10'd110; bus.bullet1_Y = 10'd110; bus.hit1 = BULLET_LIVE;
        frame();
        bus.hit1 = BULLET_NONE;
        total++; if (bus.state !== OVER || bus.winner !== 2'b10) begin bad++; $display("FAIL p1_win got st=%0d win=%b want OVER/10", bus.state, bus.winner); end
        total++; if (bus.score0 !== 4'd0 || bus.score1 !== 4'd5) begin bad++; $display("FAIL p1_win_score got %0d/%0d want 0/5", bus.score0, bus.score1); end
        rr0 = rr_cnt;
        @(negedge Clk) Reset = 1'b0;
        #1;
        total++; if (bus.state !== IDLE || bus.score1 !== 4'd0 || bus.winner !== 2'b00) begin bad++; $display("FAIL over_reset got st=%0d score1=%0d win=%b want IDLE/0/00", bus.state, bus.score1, bus.winner); end
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        total++; if (rr_cnt !== rr0 || bus.state !== IDLE) begin bad++; $display("FAIL over_reset_rr got rr=%0d st=%0d want 0/IDLE", rr_cnt - rr0, bus.state); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit_freeze();
        test_edges();
        test_own_bullet();
`ifdef BULLET_CLASH_EN
        test_clash();
`endif
        test_simultaneous();
        test_single_win_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
